// File: rtl/counter_pkg.sv
// Shared defaults and helpers for the wrap-around counter and its optional hit tracker.
package counter_pkg;

    localparam int COUNTER_DEF_WIDTH = 4;
    localparam logic [COUNTER_DEF_WIDTH-1:0] COUNTER_DEF_MAX = 4'hF;
    localparam int COUNTER_DEF_MAX_REPEATS = 5;

    // Never returns 0 so a port built from it always has at least one bit.
    function automatic int clog2_sat(input int value);
        if (value <= 2) begin
            return 1;
        end
        return $clog2(value);
    endfunction

endpackage

// File: rtl/counter_hit_tracker.sv
// Saturating count of cycles spent at the terminal value; used only with COUNTER_HIT_CNT_EN.
module counter_hit_tracker
    import counter_pkg::*;
#(
    parameter int MAX_REPEATS = COUNTER_DEF_MAX_REPEATS,
    parameter int HIT_WIDTH = clog2_sat(MAX_REPEATS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 at_max,
    output logic [HIT_WIDTH-1:0] hit_cnt,
    output logic                 hit_sat
);

    localparam logic [HIT_WIDTH-1:0] SAT_VALUE = HIT_WIDTH'(MAX_REPEATS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt <= '0;
        end else if (at_max && (hit_cnt < SAT_VALUE)) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

    assign hit_sat = (hit_cnt == SAT_VALUE);

endmodule

// File: rtl/counter.sv
// Free-running wrap-around up-counter with terminal and wrap flags.
// Defining COUNTER_HIT_CNT_EN adds the hit_cnt/hit_sat saturating tracker ports.
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_DEF_WIDTH,
    parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
    parameter int MAX_REPEATS = COUNTER_DEF_MAX_REPEATS
) (
    input  logic                                  clk,
    input  logic                                  reset,
    output logic [WIDTH-1:0]                      count,
    output logic                                  at_max,
`ifdef COUNTER_HIT_CNT_EN
    output logic [clog2_sat(MAX_REPEATS + 1)-1:0] hit_cnt,
    output logic                                  hit_sat,
`endif
    output logic                                  wrap
);

    assign at_max = (count == MAX_VALUE);

    // Values above MAX_VALUE (only reachable by forcing) roll over naturally at 2^WIDTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= at_max ? '0 : count + 1'b1;
            wrap  <= at_max;
        end
    end

`ifdef COUNTER_HIT_CNT_EN
    counter_hit_tracker #(
        .MAX_REPEATS(MAX_REPEATS)
    ) u_hit_tracker (
        .clk     (clk),
        .reset   (reset),
        .at_max  (at_max),
        .hit_cnt (hit_cnt),
        .hit_sat (hit_sat)
    );
`endif

endmodule

// File: tb/tb_counter.sv
// Randomised self-checking bench for counter: three parameterisations against an arithmetic model.
// The hit tracker checks are compiled in only when COUNTER_HIT_CNT_EN is defined.
module tb_counter;
    import counter_pkg::*;

    localparam int HIT_W = clog2_sat(COUNTER_DEF_MAX_REPEATS + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic [3:0] count_def;
    logic       at_max_def;
    logic       wrap_def;
    logic [3:0] count_nine;
    logic       at_max_nine;
    logic       wrap_nine;
    logic [0:0] count_one;
    logic       at_max_one;
    logic       wrap_one;
`ifdef COUNTER_HIT_CNT_EN
    logic [HIT_W-1:0] hit_cnt_def;
    logic             hit_sat_def;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int steps = 0;

    always #5 clk = ~clk;

    counter u_def (
        .clk    (clk),
        .reset  (reset),
        .count  (count_def),
        .at_max (at_max_def),
`ifdef COUNTER_HIT_CNT_EN
        .hit_cnt(hit_cnt_def),
        .hit_sat(hit_sat_def),
`endif
        .wrap   (wrap_def)
    );

    counter #(.WIDTH(4), .MAX_VALUE(4'd9)) u_nine (
        .clk    (clk),
        .reset  (reset),
        .count  (count_nine),
        .at_max (at_max_nine),
`ifdef COUNTER_HIT_CNT_EN
        .hit_cnt(),
        .hit_sat(),
`endif
        .wrap   (wrap_nine)
    );

    counter #(.WIDTH(1), .MAX_VALUE(1'b1)) u_one (
        .clk    (clk),
        .reset  (reset),
        .count  (count_one),
        .at_max (at_max_one),
`ifdef COUNTER_HIT_CNT_EN
        .hit_cnt(),
        .hit_sat(),
`endif
        .wrap   (wrap_one)
    );

    // Reference: everything follows from the number of clock edges since reset was released.
    always @(posedge clk or negedge reset) begin
        if (!reset) steps <= 0;
        else        steps <= steps + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (steps=%0d)", tag, observed, expected, steps);
        end
    endtask

    task automatic checkConfig(input string name, input int max_value,
                               input logic [31:0] cnt, input logic am, input logic wr);
        int exp_count;
        exp_count = steps % (max_value + 1);
        checkOutput({name, ".count"}, cnt, exp_count);
        checkOutput({name, ".at_max"}, {31'd0, am}, (exp_count == max_value) ? 1 : 0);
        checkOutput({name, ".wrap"}, {31'd0, wr}, (steps > 0 && exp_count == 0) ? 1 : 0);
    endtask

    task automatic checkAll();
`ifdef COUNTER_HIT_CNT_EN
        int exp_hits;
`endif
        checkConfig("def", 15, {28'd0, count_def}, at_max_def, wrap_def);
        checkConfig("nine", 9, {28'd0, count_nine}, at_max_nine, wrap_nine);
        checkConfig("one", 1, {31'd0, count_one}, at_max_one, wrap_one);
`ifdef COUNTER_HIT_CNT_EN
        exp_hits = steps / 16;
        if (exp_hits > COUNTER_DEF_MAX_REPEATS) exp_hits = COUNTER_DEF_MAX_REPEATS;
        checkOutput("def.hit_cnt", 32'(hit_cnt_def), exp_hits);
        checkOutput("def.hit_sat", {31'd0, hit_sat_def},
                    (exp_hits == COUNTER_DEF_MAX_REPEATS) ? 1 : 0);
`endif
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            checkAll();
        end
    endtask

    // Asserts reset between edges, checks the immediate effect, then releases on a falling edge.
    task automatic asyncReset(input int offset, input int hold_cycles);
        #(offset);
        reset = 1'b0;
        #1;
        checkAll();
        checkOutput("async.count_zero", {28'd0, count_def}, 32'd0);
        repeat (hold_cycles) begin
            @(negedge clk);
            checkAll();
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkAll();
        reset = 1'b1;
        applyStimulus(20);

        asyncReset(2, 0);
        applyStimulus(7);
        checkOutput("mid.count_seven", {28'd0, count_def}, 32'd7);
        asyncReset(2, 0);
        applyStimulus(1);
        checkOutput("mid.count_one", {28'd0, count_def}, 32'd1);

        applyStimulus(100);

        for (int i = 0; i < 12; i++) begin
            asyncReset($urandom_range(1, 4), $urandom_range(0, 2));
            applyStimulus($urandom_range(1, 90));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
